// File: rtl/sram_arbiter_if.sv
// Signal bundle between sram_arbiter, its two requesters and the SRAM pins.
// The arbiter takes the slave modport; requesters plus the SRAM device take master.
interface sram_arbiter_if;
  logic        cpu_req;
  logic        cpu_read;
  logic [17:0] cpu_address;
  logic        cpu_ub;
  logic        cpu_lb;
  logic [15:0] cpu_data_in;
  logic [15:0] cpu_data_out;
  logic        cpu_ack;
  logic        spi_req;
  logic        spi_ack;
  logic        spi_read_sram;
  logic [17:0] spi_address_sram;
  logic        spi_ub;
  logic [7:0]  spi_out_sram_in;
  logic [15:0] spi_in_sram_out;
  logic [17:0] sram_a;
  logic [15:0] sram_d_out;
  logic [15:0] sram_d_in;
  logic        sram_d_oe;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  modport master (
    output cpu_req, cpu_read, cpu_address, cpu_ub, cpu_lb, cpu_data_in,
    output spi_req, spi_read_sram, spi_address_sram, spi_ub, spi_out_sram_in,
    output sram_d_in,
    input  cpu_data_out, cpu_ack, spi_ack, spi_in_sram_out,
    input  sram_a, sram_d_out, sram_d_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );

  modport slave (
    input  cpu_req, cpu_read, cpu_address, cpu_ub, cpu_lb, cpu_data_in,
    input  spi_req, spi_read_sram, spi_address_sram, spi_ub, spi_out_sram_in,
    input  sram_d_in,
    output cpu_data_out, cpu_ack, spi_ack, spi_in_sram_out,
    output sram_a, sram_d_out, sram_d_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 256K x 16 SRAM between the cpu and SPI requesters.
// Define ROUND_ROBIN_EN to alternate priority when both requesters are pending.
module sram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 11
) (
  input  logic          clk200,
  input  logic          reset_n,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam logic [4:0] CNT_LOAD = 5'(ACCESS_CYCLES - 32'd1);

  state_t      state_r, state_nx_s;
  logic [4:0]  cnt_r, cnt_nx_s;
  logic        is_read_r, is_read_nx_s;
  logic        is_cpu_r, is_cpu_nx_s;
  logic [17:0] sram_a_r, sram_a_nx_s;
  logic [15:0] sram_d_out_r, sram_d_out_nx_s;
  logic        sram_d_oe_r, sram_d_oe_nx_s;
  logic        sram_oe_n_r, sram_oe_n_nx_s;
  logic        sram_we_n_r, sram_we_n_nx_s;
  logic        sram_ub_n_r, sram_ub_n_nx_s;
  logic        sram_lb_n_r, sram_lb_n_nx_s;
  logic        cpu_ack_r, cpu_ack_nx_s;
  logic        spi_ack_r, spi_ack_nx_s;
  logic [15:0] cpu_dout_r, cpu_dout_nx_s;
  logic [15:0] spi_din_r, spi_din_nx_s;
  logic        idle_s, cpu_pend_s, spi_pend_s;
  logic        grant_cpu_s, grant_spi_s;
`ifdef ROUND_ROBIN_EN
  logic        last_cpu_r, last_cpu_nx_s;
`endif

  // Pending detection and winner selection, only meaningful in IDLE
  always_comb begin
    idle_s     = (state_r == ST_IDLE);
    cpu_pend_s = bus.cpu_req;
    spi_pend_s = (bus.spi_req != spi_ack_r);
`ifdef ROUND_ROBIN_EN
    if (cpu_pend_s && spi_pend_s) begin
      grant_cpu_s = idle_s && !last_cpu_r;
    end else begin
      grant_cpu_s = idle_s && cpu_pend_s;
    end
`else
    grant_cpu_s = idle_s && cpu_pend_s;
`endif
    grant_spi_s = idle_s && spi_pend_s && !grant_cpu_s;
  end

  // State register
  always_ff @(posedge clk200) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_cpu_s || grant_spi_s) begin
          state_nx_s = ST_ACCESS;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == 5'd0) begin
          state_nx_s = ST_RECOVER;
        end else begin
          state_nx_s = ST_ACCESS;
        end
      end
      ST_RECOVER: state_nx_s = ST_IDLE;
      default:    state_nx_s = ST_IDLE;
    endcase
  end

  // Next values of pin, handshake and datapath registers
  always_comb begin
    cnt_nx_s        = cnt_r;
    is_read_nx_s    = is_read_r;
    is_cpu_nx_s     = is_cpu_r;
    sram_a_nx_s     = sram_a_r;
    sram_d_out_nx_s = sram_d_out_r;
    sram_d_oe_nx_s  = sram_d_oe_r;
    sram_oe_n_nx_s  = sram_oe_n_r;
    sram_we_n_nx_s  = sram_we_n_r;
    sram_ub_n_nx_s  = sram_ub_n_r;
    sram_lb_n_nx_s  = sram_lb_n_r;
    cpu_ack_nx_s    = 1'b0;
    spi_ack_nx_s    = spi_ack_r;
    cpu_dout_nx_s   = cpu_dout_r;
    spi_din_nx_s    = spi_din_r;
`ifdef ROUND_ROBIN_EN
    if (grant_cpu_s) begin
      last_cpu_nx_s = 1'b1;
    end else if (grant_spi_s) begin
      last_cpu_nx_s = 1'b0;
    end else begin
      last_cpu_nx_s = last_cpu_r;
    end
`endif
    case (state_r)
      ST_IDLE: begin
        if (grant_cpu_s) begin
          cnt_nx_s        = CNT_LOAD;
          is_cpu_nx_s     = 1'b1;
          is_read_nx_s    = bus.cpu_read;
          sram_a_nx_s     = bus.cpu_address;
          sram_d_out_nx_s = bus.cpu_data_in;
          sram_ub_n_nx_s  = ~bus.cpu_ub;
          sram_lb_n_nx_s  = ~bus.cpu_lb;
          sram_oe_n_nx_s  = ~bus.cpu_read;
          sram_we_n_nx_s  = bus.cpu_read;
          sram_d_oe_nx_s  = ~bus.cpu_read;
        end else if (grant_spi_s) begin
          cnt_nx_s        = CNT_LOAD;
          is_cpu_nx_s     = 1'b0;
          is_read_nx_s    = bus.spi_read_sram;
          sram_a_nx_s     = bus.spi_address_sram;
          sram_d_out_nx_s = {bus.spi_out_sram_in, bus.spi_out_sram_in};
          sram_oe_n_nx_s  = ~bus.spi_read_sram;
          sram_we_n_nx_s  = bus.spi_read_sram;
          sram_d_oe_nx_s  = ~bus.spi_read_sram;
          // A read fetches the whole word; a write lands on one byte lane
          if (bus.spi_read_sram) begin
            sram_ub_n_nx_s = 1'b0;
            sram_lb_n_nx_s = 1'b0;
          end else begin
            sram_ub_n_nx_s = ~bus.spi_ub;
            sram_lb_n_nx_s = bus.spi_ub;
          end
        end else begin
          sram_d_oe_nx_s = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == 5'd0) begin
          sram_oe_n_nx_s = 1'b1;
          sram_we_n_nx_s = 1'b1;
          sram_ub_n_nx_s = 1'b1;
          sram_lb_n_nx_s = 1'b1;
          if (is_cpu_r) begin
            cpu_ack_nx_s = 1'b1;
            if (is_read_r) begin
              cpu_dout_nx_s = bus.sram_d_in;
            end else begin
              cpu_dout_nx_s = cpu_dout_r;
            end
          end else begin
            spi_ack_nx_s = ~spi_ack_r;
            if (is_read_r) begin
              spi_din_nx_s = bus.sram_d_in;
            end else begin
              spi_din_nx_s = spi_din_r;
            end
          end
        end else begin
          cnt_nx_s = cnt_r - 5'd1;
        end
      end
      ST_RECOVER: begin
        // Write data was held through RECOVER; release the bus now
        sram_d_oe_nx_s = 1'b0;
      end
      default: begin
        sram_d_oe_nx_s = 1'b0;
        sram_oe_n_nx_s = 1'b1;
        sram_we_n_nx_s = 1'b1;
        sram_ub_n_nx_s = 1'b1;
        sram_lb_n_nx_s = 1'b1;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk200) begin
    if (!reset_n) begin
      cnt_r        <= 5'd0;
      is_read_r    <= 1'b0;
      is_cpu_r     <= 1'b0;
      sram_a_r     <= 18'd0;
      sram_d_out_r <= 16'd0;
      sram_d_oe_r  <= 1'b0;
      sram_oe_n_r  <= 1'b1;
      sram_we_n_r  <= 1'b1;
      sram_ub_n_r  <= 1'b1;
      sram_lb_n_r  <= 1'b1;
      cpu_ack_r    <= 1'b0;
      spi_ack_r    <= 1'b0;
      cpu_dout_r   <= 16'd0;
      spi_din_r    <= 16'd0;
`ifdef ROUND_ROBIN_EN
      last_cpu_r   <= 1'b0;
`endif
    end else begin
      cnt_r        <= cnt_nx_s;
      is_read_r    <= is_read_nx_s;
      is_cpu_r     <= is_cpu_nx_s;
      sram_a_r     <= sram_a_nx_s;
      sram_d_out_r <= sram_d_out_nx_s;
      sram_d_oe_r  <= sram_d_oe_nx_s;
      sram_oe_n_r  <= sram_oe_n_nx_s;
      sram_we_n_r  <= sram_we_n_nx_s;
      sram_ub_n_r  <= sram_ub_n_nx_s;
      sram_lb_n_r  <= sram_lb_n_nx_s;
      cpu_ack_r    <= cpu_ack_nx_s;
      spi_ack_r    <= spi_ack_nx_s;
      cpu_dout_r   <= cpu_dout_nx_s;
      spi_din_r    <= spi_din_nx_s;
`ifdef ROUND_ROBIN_EN
      last_cpu_r   <= last_cpu_nx_s;
`endif
    end
  end

  assign bus.sram_a          = sram_a_r;
  assign bus.sram_d_out      = sram_d_out_r;
  assign bus.sram_d_oe       = sram_d_oe_r;
  assign bus.sram_oe_n       = sram_oe_n_r;
  assign bus.sram_we_n       = sram_we_n_r;
  assign bus.sram_ub_n       = sram_ub_n_r;
  assign bus.sram_lb_n       = sram_lb_n_r;
  assign bus.cpu_ack         = cpu_ack_r;
  assign bus.spi_ack         = spi_ack_r;
  assign bus.cpu_data_out    = cpu_dout_r;
  assign bus.spi_in_sram_out = spi_din_r;

endmodule
